instr_mem_loader: RTL and testbench

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 168 ++++++++++++++++
 tb/tb_instr_mem_loader.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Byte-stream instruction-memory loader: packs little-endian bytes into 32-bit
// words, writes them to consecutive word addresses, then releases core reset.
module instr_mem_loader #(
  parameter int DEPTH = 1024,
  parameter int LEN_W = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wd,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             core_rst
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] ONE_L   = LEN_W'(1);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      word_q, word_d;
  logic             in_ready_q, in_ready_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wd_q, mem_wd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             core_rst_q, core_rst_d;
  logic             xfer_s;
  logic             len_ok_s;

  // in_ready_q is high exactly while the FSM sits in LOAD.
  assign xfer_s   = in_valid & in_ready_q;
  assign len_ok_s = (len != {LEN_W{1'b0}}) && (len <= DEPTH_L);

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    err_d      = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (len_ok_s) begin
            len_d      = len;
            word_cnt_d = {LEN_W{1'b0}};
            byte_cnt_d = 2'd0;
            word_d     = 32'd0;
            state_d    = LOAD;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = state_q;
        end
      end
      LOAD: begin
        if (xfer_s) begin
          case (byte_cnt_q)
            2'd0:    word_d[7:0]   = in_byte;
            2'd1:    word_d[15:8]  = in_byte;
            2'd2:    word_d[23:16] = in_byte;
            2'd3:    word_d[31:24] = in_byte;
            default: word_d        = word_q;
          endcase
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = WRITE;
          end else begin
            state_d = LOAD;
          end
        end else begin
          state_d = LOAD;
        end
      end
      WRITE: begin
        if (word_cnt_q == (len_q - ONE_L)) begin
          state_d = DONE;
        end else begin
          word_cnt_d = word_cnt_q + ONE_L;
          state_d    = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are a function of the next state so they register in step with it.
    in_ready_d = (state_d == LOAD);
    mem_we_d   = (state_d == WRITE);
    busy_d     = (state_d == LOAD) || (state_d == WRITE);
    done_d     = (state_d == DONE);
    core_rst_d = (state_d == DONE);
    if (state_d == WRITE) begin
      mem_addr_d = 32'({word_cnt_d, 2'b00});
      mem_wd_d   = word_d;
    end else begin
      mem_addr_d = mem_addr_q;
      mem_wd_d   = mem_wd_q;
    end
  end

  // State, datapath and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      len_q      <= {LEN_W{1'b0}};
      word_cnt_q <= {LEN_W{1'b0}};
      byte_cnt_q <= 2'd0;
      word_q     <= 32'd0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_wd_q   <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      core_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      core_rst_q <= core_rst_d;
    end
  end

  assign in_ready = in_ready_q;
  assign mem_we   = mem_we_q;
  assign mem_addr = mem_addr_q;
  assign mem_wd   = mem_wd_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign core_rst = core_rst_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed self-checking bench for instr_mem_loader with hand-computed vectors.
module tb_instr_mem_loader;

  localparam int LEN_W = 11;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic [7:0]       in_byte;
  logic             in_ready;
  logic             mem_we;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wd;
  logic             busy;
  logic             done;
  logic             err;
  logic             core_rst;

  int n_cmp;
  int n_bad;
  int we_cnt;
  int err_cnt;

  instr_mem_loader #(.DEPTH(1024), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_byte  (in_byte),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wd   (mem_wd),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .core_rst (core_rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write strobes and error cycles away from the active edge.
  always @(negedge clk) begin
    if (mem_we) we_cnt = we_cnt + 1;
    if (err)    err_cnt = err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [LEN_W-1:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  // Idle `gap` cycles, then present one byte until it is taken (bounded wait).
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit taken;
    for (int g = 0; g < gap; g++) tick();
    in_valid = 1'b1;
    in_byte  = b;
    taken    = 1'b0;
    for (int t = 0; t < 100 && !taken; t++) begin
      if (in_ready) taken = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!taken) check("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_mem_we"},   {31'd0, mem_we},   32'd0);
    check({tag, "_mem_addr"}, mem_addr,          32'd0);
    check({tag, "_mem_wd"},   mem_wd,            32'd0);
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    check({tag, "_done"},     {31'd0, done},     32'd0);
    check({tag, "_err"},      {31'd0, err},      32'd0);
    check({tag, "_core_rst"}, {31'd0, core_rst}, 32'd0);
  endtask

  initial begin
    int we0;
    n_cmp = 0; n_bad = 0; we_cnt = 0; err_cnt = 0;
    rst = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_byte = 8'h00;
    tick(); tick();
    check_reset_outputs("rst");
    rst = 1'b1;
    tick();

    // len=1 single word
    pulse_start(11'd1);
    check("t1_busy",     {31'd0, busy},     32'd1);
    check("t1_in_ready", {31'd0, in_ready}, 32'd1);
    send_byte(8'h33, 0); send_byte(8'hE2, 0); send_byte(8'h62, 0); send_byte(8'h00, 0);
    check("t1_we",       {31'd0, mem_we},   32'd1);
    check("t1_addr",     mem_addr,          32'h0);
    check("t1_wd",       mem_wd,            32'h0062E233);
    check("t1_rdy_wr",   {31'd0, in_ready}, 32'd0);
    check("t1_core_lo",  {31'd0, core_rst}, 32'd0);
    tick();
    check("t1_we_off",   {31'd0, mem_we},   32'd0);
    check("t1_done",     {31'd0, done},     32'd1);
    check("t1_core_rst", {31'd0, core_rst}, 32'd1);
    check("t1_busy_off", {31'd0, busy},     32'd0);
    check("t1_nwrites",  we_cnt,            32'd1);

    // len=2 restarted from DONE
    pulse_start(11'd2);
    check("t2_done_off", {31'd0, done},     32'd0);
    check("t2_core_off", {31'd0, core_rst}, 32'd0);
    send_byte(8'h03, 0); send_byte(8'hA3, 0); send_byte(8'hC4, 0); send_byte(8'hFF, 0);
    check("t2_we0",      {31'd0, mem_we},   32'd1);
    check("t2_rdy0",     {31'd0, in_ready}, 32'd0);
    check("t2_addr0",    mem_addr,          32'h0);
    check("t2_wd0",      mem_wd,            32'hFFC4A303);
    send_byte(8'h83, 0); send_byte(8'h23, 0); send_byte(8'h83, 0); send_byte(8'h00, 0);
    check("t2_we1",      {31'd0, mem_we},   32'd1);
    check("t2_rdy1",     {31'd0, in_ready}, 32'd0);
    check("t2_addr1",    mem_addr,          32'h4);
    check("t2_wd1",      mem_wd,            32'h00832383);
    tick();
    check("t2_done",     {31'd0, done},     32'd1);
    check("t2_nwrites",  we_cnt,            32'd3);

    // rejected starts: len=0 from DONE, len=1025 from IDLE
    we0 = we_cnt;
    pulse_start(11'd0);
    check("t3a_err",     {31'd0, err},      32'd1);
    check("t3a_done",    {31'd0, done},     32'd0);
    check("t3a_busy",    {31'd0, busy},     32'd0);
    check("t3a_rdy",     {31'd0, in_ready}, 32'd0);
    tick();
    check("t3a_err_off", {31'd0, err},      32'd0);
    pulse_start(11'd1025);
    check("t3b_err",     {31'd0, err},      32'd1);
    check("t3b_busy",    {31'd0, busy},     32'd0);
    tick();
    check("t3b_err_off", {31'd0, err},      32'd0);
    check("t3_busy",     {31'd0, busy},     32'd0);
    check("t3_nwrites",  we_cnt,            we0);
    check("t3_errcyc",   err_cnt,           32'd2);

    // gapped bytes with an ignored mid-load start
    pulse_start(11'd1);
    send_byte(8'h33, 5); send_byte(8'hE2, 5);
    pulse_start(11'd2);
    check("t4_noerr",    {31'd0, err},      32'd0);
    check("t4_busy",     {31'd0, busy},     32'd1);
    send_byte(8'h62, 5); send_byte(8'h00, 5);
    check("t4_we",       {31'd0, mem_we},   32'd1);
    check("t4_addr",     mem_addr,          32'h0);
    check("t4_wd",       mem_wd,            32'h0062E233);
    tick();
    check("t4_done",     {31'd0, done},     32'd1);
    check("t4_nwrites",  we_cnt,            we0 + 1);
    check("t4_errcyc",   err_cnt,           32'd2);

    // reset mid-load at the DEPTH boundary length, then reload
    we0 = we_cnt;
    pulse_start(11'd1024);
    check("t5_busy",     {31'd0, busy},     32'd1);
    send_byte(8'hAA, 0); send_byte(8'hBB, 0);
    rst = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    tick(); tick();
    check("t5_nwrites",  we_cnt,            we0);
    rst = 1'b1;
    tick();
    pulse_start(11'd1);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h33, 0); send_byte(8'h44, 0);
    check("t5_we",       {31'd0, mem_we},   32'd1);
    check("t5_addr",     mem_addr,          32'h0);
    check("t5_wd",       mem_wd,            32'h44332211);
    tick();
    check("t5_done",     {31'd0, done},     32'd1);
    check("t5_nwrites",  we_cnt,            we0 + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
